hex_keypad_scanner: RTL and testbench

//   Scans a 4x4 PmodKYPD hex keypad. Drives one column low at a time and samples the rows.

---
 rtl/hex_keypad_scanner.sv | 224 ++++++++++++++++++++++
 tb/tb_hex_keypad_scanner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_scanner.sv
// 4x4 PmodKYPD scanner: column drive, row synchronizer, frame debounce, one pulse per press.
// Optional auto-repeat while a key is held is compiled in with `define KEYPAD_REPEAT_EN.
module hex_keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_FRAMES  = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  input  logic        clear,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [15:0] data
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } frame_res_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_e;

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("DEBOUNCE_SCANS must be >= 1");
  end
  if (REPEAT_FRAMES < 1) begin : g_bad_repeat
    $error("REPEAT_FRAMES must be >= 1");
  end

  // Row r / column c position to hex value.
  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_lut = 4'h1;  4'h1: key_lut = 4'h2;  4'h2: key_lut = 4'h3;  4'h3: key_lut = 4'hA;
      4'h4: key_lut = 4'h4;  4'h5: key_lut = 4'h5;  4'h6: key_lut = 4'h6;  4'h7: key_lut = 4'hB;
      4'h8: key_lut = 4'h7;  4'h9: key_lut = 4'h8;  4'hA: key_lut = 4'h9;  4'hB: key_lut = 4'hC;
      4'hC: key_lut = 4'h0;  4'hD: key_lut = 4'hF;  4'hE: key_lut = 4'hE;  default: key_lut = 4'hD;
    endcase
  endfunction

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       hits_q, hits_d;
  logic [3:0]       acc_code_q, acc_code_d;
  frame_res_e       prev_res_q, prev_res_d;
  logic [3:0]       prev_code_q, prev_code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [15:0]      data_q, data_d;

  logic             slot_end, frame_end, stable;
  logic [3:0]       pressed;
  logic [2:0]       n_low, hits_sum;
  logic [1:0]       low_row, hits_new;
  logic [3:0]       code_new;
  frame_res_e       res;
  logic             accept;
  logic [3:0]       accept_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  // NOTE: every signal written in an always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    slot_end  = (div_q == DIV_W'(SCAN_DIV - 1));
    frame_end = slot_end && (col_idx_q == 2'd3);
    div_d     = slot_end ? '0 : div_q + DIV_W'(1);
    col_idx_d = slot_end ? col_idx_q + 2'd1 : col_idx_q;

    pressed  = ~row_sync_q;
    n_low    = {2'b00, pressed[0]} + {2'b00, pressed[1]} + {2'b00, pressed[2]} + {2'b00, pressed[3]};
    low_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (pressed[r]) low_row = 2'(r);
    end
    hits_sum = {1'b0, hits_q} + n_low;
    hits_new = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    // With a single hit so far the code already captured stays; otherwise it comes from this slot.
    code_new = (hits_q == 2'd0) ? key_lut(low_row, col_idx_q) : acc_code_q;

    case (hits_new)
      2'd0:    res = RES_NONE;
      2'd1:    res = RES_KEY;
      default: res = RES_MULTI;
    endcase

    hits_d     = hits_q;
    acc_code_d = acc_code_q;
    if (slot_end) begin
      hits_d     = frame_end ? 2'd0 : hits_new;
      acc_code_d = code_new;
    end
  end

  always_comb begin
    prev_res_d  = prev_res_q;
    prev_code_d = prev_code_q;
    cnt_d       = cnt_q;
    if (frame_end) begin
      prev_res_d  = res;
      prev_code_d = code_new;
      if (res == RES_MULTI) begin
        cnt_d = '0;
      end else if ((res == prev_res_q) && ((res == RES_NONE) || (code_new == prev_code_q))) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = CNT_W'(1);
      end
    end
    stable = (cnt_d == CNT_MAX);
  end

  always_comb begin
    state_d     = state_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    data_d      = clear ? 16'h0000 : data_q;
    accept      = 1'b0;
    accept_code = key_code_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif
    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if ((res == RES_KEY) && stable) begin
            state_d     = ST_PRESSED;
            accept      = 1'b1;
            accept_code = code_new;
`ifdef KEYPAD_REPEAT_EN
            rep_d       = '0;
`endif
          end
        end
        ST_PRESSED: begin
          if ((res == RES_NONE) && stable) state_d = ST_IDLE;
`ifdef KEYPAD_REPEAT_EN
          // Only frames showing the accepted key alone advance the repeat count.
          if ((res == RES_KEY) && (code_new == key_code_q)) begin
            if (rep_q == REP_W'(REPEAT_FRAMES - 1)) begin
              rep_d  = '0;
              accept = 1'b1;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
          end else begin
            rep_d = '0;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = accept_code;
      data_d      = clear ? {12'h000, accept_code} : {data_q[11:0], accept_code};
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments; always_comb uses blocking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q  <= '0;
      row_sync_q  <= '0;
      div_q       <= '0;
      col_idx_q   <= '0;
      hits_q      <= '0;
      acc_code_q  <= '0;
      prev_res_q  <= RES_NONE;
      prev_code_q <= '0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      data_q      <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      row_meta_q  <= row;
      row_sync_q  <= row_meta_q;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      hits_q      <= hits_d;
      acc_code_q  <= acc_code_d;
      prev_res_q  <= prev_res_d;
      prev_code_q <= prev_code_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      data_q      <= data_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = (state_q == ST_PRESSED);
  assign data      = data_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: keypad model drives rows from col; frame-level reference model
// plus a table of hand-derived group results and a few hand-written reset / repeat sequences.
module tb_hex_keypad_scanner;

  localparam int SD = 4;
  localparam int DS = 2;
  localparam int RF = 3;

  localparam logic [3:0] KMAP [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic        clear;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] data;

  logic [15:0] mask = '0;  // bit v set = key with hex value v is held

  int checks = 0;
  int errors = 0;

  // Frame-level reference model state.
  int          m_prev, m_prev_code, m_cnt, m_rep;
  bit          m_held;
  logic [3:0]  m_code;
  logic [15:0] m_data;

  hex_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .REPEAT_FRAMES(RF)) dut (
    .clk(clk), .reset(reset), .row(row), .clear(clear), .col(col),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .data(data)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && mask[KMAP[r*4+c]]) row[r] = 1'b0;
  end

  function automatic logic [15:0] k(input int v);
    logic [15:0] one;
    one = 16'h0001;
    return one << v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_prev_code = 0; m_cnt = 0; m_rep = 0;
    m_held = 1'b0; m_code = '0; m_data = '0;
  endtask

  task automatic model_frame(input logic [15:0] m, input bit clr_i, output bit pulse);
    int n, res, kc;
    n  = $countones(m);
    kc = 0;
    for (int v = 0; v < 16; v++) if (m[v]) kc = v;
    res = (n == 0) ? 0 : (n == 1) ? 1 : 2;
    if (res == 2) m_cnt = 0;
    else if (res == m_prev && (res == 0 || kc == m_prev_code)) m_cnt = (m_cnt < DS) ? m_cnt + 1 : DS;
    else m_cnt = 1;
    m_prev = res;
    m_prev_code = kc;
    pulse = 1'b0;
    if (!m_held) begin
      if (res == 1 && m_cnt == DS) begin
        m_held = 1'b1; m_code = 4'(kc); pulse = 1'b1; m_rep = 0;
      end
    end else begin
      if (res == 0 && m_cnt == DS) m_held = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      if (res == 1 && 4'(kc) == m_code) begin
        m_rep++;
        if (m_rep == RF) begin pulse = 1'b1; m_rep = 0; end
      end else m_rep = 0;
`endif
    end
    if (pulse) m_data = clr_i ? {12'h000, m_code} : {m_data[11:0], m_code};
    else if (clr_i) m_data = '0;
  endtask

  // Starts #1 after a frame-end edge (or reset release); ends #1 after the next frame-end edge.
  task automatic run_frame(input logic [15:0] m, input bit clr_i, output int seen);
    int         extra;
    bit         col_bad, exp_pulse;
    logic [3:0] exp_col;
    extra   = 0;
    col_bad = 1'b0;
    mask    = m;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i > 0 && key_valid) extra++;
      exp_col = ~(4'b0001 << (i / 4));
      if (col !== exp_col) col_bad = 1'b1;
      if (i == 15) clear = clr_i;
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_frame(m, clr_i, exp_pulse);
    check("key_valid", key_valid, exp_pulse);
    check("key_code", key_code, m_code);
    check("data", data, m_data);
    check("key_held", key_held, m_held);
    check("stray_pulse", extra, 0);
    check("col_seq", col_bad, 0);
    seen = extra + (key_valid ? 1 : 0);
  endtask

  typedef struct {
    logic [15:0] m;
    int          frames;
    bit          clr;     // clear during the last frame-end cycle of the group
    int          pulses;
    logic [3:0]  code;
    logic [15:0] dat;
    bit          held;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int seen, total, hold;
    logic [15:0] m;
    bit clr_r;

    tbl.push_back('{k(5), 2, 0, 1, 4'h5, 16'h0005, 1});
    tbl.push_back('{16'h0, 3, 0, 0, 4'h5, 16'h0005, 0});
    tbl.push_back('{k(1), 3, 0, 1, 4'h1, 16'h0051, 1});
    tbl.push_back('{16'h0, 3, 0, 0, 4'h1, 16'h0051, 0});
    tbl.push_back('{k(2), 3, 0, 1, 4'h2, 16'h0512, 1});
    tbl.push_back('{16'h0, 3, 0, 0, 4'h2, 16'h0512, 0});
    tbl.push_back('{k(3), 3, 0, 1, 4'h3, 16'h5123, 1});
    tbl.push_back('{16'h0, 3, 0, 0, 4'h3, 16'h5123, 0});
    tbl.push_back('{k(10), 3, 0, 1, 4'hA, 16'h123A, 1});
    tbl.push_back('{16'h0, 3, 0, 0, 4'hA, 16'h123A, 0});
    tbl.push_back('{k(11), 3, 0, 1, 4'hB, 16'h23AB, 1});
    tbl.push_back('{16'h0, 3, 0, 0, 4'hB, 16'h23AB, 0});
    tbl.push_back('{k(7), 1, 0, 0, 4'hB, 16'h23AB, 0});
    tbl.push_back('{16'h0, 2, 0, 0, 4'hB, 16'h23AB, 0});
    tbl.push_back('{k(1) | k(2), 4, 0, 0, 4'hB, 16'h23AB, 0});
    tbl.push_back('{k(1), 2, 0, 1, 4'h1, 16'h3AB1, 1});
    tbl.push_back('{16'h0, 2, 0, 0, 4'h1, 16'h3AB1, 0});
    tbl.push_back('{k(1), 2, 0, 1, 4'h1, 16'hAB11, 1});
    tbl.push_back('{16'h0, 2, 0, 0, 4'h1, 16'hAB11, 0});
    tbl.push_back('{k(2), 2, 0, 1, 4'h2, 16'hB112, 1});
    tbl.push_back('{16'h0, 2, 0, 0, 4'h2, 16'hB112, 0});
    tbl.push_back('{k(3), 2, 0, 1, 4'h3, 16'h1123, 1});
    tbl.push_back('{16'h0, 2, 0, 0, 4'h3, 16'h1123, 0});
    tbl.push_back('{k(4), 2, 0, 1, 4'h4, 16'h1234, 1});
    tbl.push_back('{16'h0, 2, 0, 0, 4'h4, 16'h1234, 0});
    tbl.push_back('{k(15), 2, 1, 1, 4'hF, 16'h000F, 1});
    tbl.push_back('{16'h0, 2, 0, 0, 4'hF, 16'h000F, 0});
    tbl.push_back('{16'h0, 1, 1, 0, 4'hF, 16'h0000, 0});

    reset = 1'b0;
    clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", col, 4'b1110);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_held", key_held, 0);
    check("rst_data", data, 0);
    reset = 1'b1;

    foreach (tbl[t]) begin
      total = 0;
      for (int f = 0; f < tbl[t].frames; f++) begin
        run_frame(tbl[t].m, tbl[t].clr && (f == tbl[t].frames - 1), seen);
        total += seen;
      end
      check($sformatf("tbl%0d_pulses", t), total, tbl[t].pulses);
      check($sformatf("tbl%0d_code", t), key_code, tbl[t].code);
      check($sformatf("tbl%0d_data", t), data, tbl[t].dat);
      check($sformatf("tbl%0d_held", t), key_held, tbl[t].held);
    end

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: m = '0;
        9:          m = k($urandom_range(0, 15)) | k($urandom_range(0, 15));
        default:    m = k($urandom_range(0, 15));
      endcase
      hold = $urandom_range(1, 5);
      for (int f = 0; f < hold; f++) begin
        clr_r = (f == hold - 1) && ($urandom_range(0, 7) == 0);
        run_frame(m, clr_r, seen);
      end
    end

    // Reset in the middle of a hold, while the third column is driven.
    repeat (3) run_frame('0, 1'b0, seen);
    repeat (2) run_frame(k(9), 1'b0, seen);
    check("pre_reset_held", key_held, 1);
    repeat (9) @(posedge clk);
    #1;
    check("pre_reset_col", col, 4'b1011);
    reset = 1'b0;
    #1;
    model_reset();
    check("mid_rst_col", col, 4'b1110);
    check("mid_rst_key_valid", key_valid, 0);
    check("mid_rst_key_code", key_code, 0);
    check("mid_rst_key_held", key_held, 0);
    check("mid_rst_data", data, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_frame(k(9), 1'b0, seen);
    check("post_rst_f1_pulse", seen, 0);
    run_frame(k(9), 1'b0, seen);
    check("post_rst_f2_pulse", seen, 1);
    check("post_rst_code", key_code, 4'h9);
    check("post_rst_data", data, 16'h0009);

`ifdef KEYPAD_REPEAT_EN
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int f = 1; f <= 11; f++) begin
      run_frame(k(14), 1'b0, seen);
      check($sformatf("repeat_f%0d", f), seen, (f % 3 == 2) ? 1 : 0);
    end
    check("repeat_data", data, 16'hEEEE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
